dmni_mem_arbiter: RTL and testbench

DMNI_MEM_ARBITER -- requirements
Module: dmni_mem_arbiter

---
 rtl/dmni_mem_arbiter_pkg.sv | 10 +
 rtl/dmni_mem_arbiter_if.sv | 38 +++
 rtl/dmni_mem_arbiter_stall_monitor.sv | 34 +++
 rtl/dmni_mem_arbiter.sv | 96 +++++++++
 tb/tb_dmni_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmni_mem_arbiter_pkg.sv
// Shared types for the DMNI/CPU memory arbiter.
package DMNIPkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_DMNI = 2'd1,
    RD_CPU  = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/dmni_mem_arbiter_if.sv
// Requester and RAM bus bundle; the arbiter takes the slave view.
interface dmni_mem_arbiter_if;
  logic        dmni_en_i;
  logic [3:0]  dmni_we_i;
  logic [31:0] dmni_addr_i;
  logic [31:0] dmni_data_i;
  logic [31:0] dmni_data_o;

  logic        cpu_req_i;
  logic [3:0]  cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_gnt_o;
  logic        cpu_rvalid_o;
  logic [31:0] cpu_data_o;

  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;

  modport slave (
    input  dmni_en_i, dmni_we_i, dmni_addr_i, dmni_data_i,
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    input  ram_data_i,
    output dmni_data_o, cpu_gnt_o, cpu_rvalid_o, cpu_data_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_data_o
  );

  modport master (
    output dmni_en_i, dmni_we_i, dmni_addr_i, dmni_data_i,
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    output ram_data_i,
    input  dmni_data_o, cpu_gnt_o, cpu_rvalid_o, cpu_data_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_data_o
  );
endinterface

// File: rtl/dmni_mem_arbiter_stall_monitor.sv
// Tracks consecutive CPU stall cycles (saturating at STALL_LIMIT) and a saturating lifetime total.
module StallMonitor #(
  parameter int STALL_LIMIT = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req,
  input  logic        gnt,
  output logic        starve,
  output logic [31:0] total
);
  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

  logic [CW-1:0] cnt_q;
  logic          stalled;

  assign stalled = req && !gnt;
  assign starve  = (cnt_q == LIMIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      total <= '0;
    end else begin
      if (!stalled)
        cnt_q <= '0;
      else if (cnt_q != LIMIT)
        cnt_q <= cnt_q + CW'(1);
      if (stalled && (total != 32'hFFFF_FFFF))
        total <= total + 32'd1;
    end
  end
endmodule

// File: rtl/dmni_mem_arbiter.sv
// Fixed-priority arbiter sharing one synchronous RAM port between the DMNI (always wins) and the CPU.
// state   | meaning
// IDLE    | no read data due this cycle
// RD_DMNI | ram_data_i carries the DMNI read issued last cycle
// RD_CPU  | ram_data_i carries the CPU read issued last cycle; rvalid pulses
module dmni_mem_arbiter
  import DMNIPkg::*;
#(
  parameter int RAM_BYTES   = 65536,
  parameter int STALL_LIMIT = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  dmni_mem_arbiter_if.slave bus,
  input  logic              oor_clr_i,
  output logic              starve_o,
  output logic              oor_err_o,
  output logic [31:0]       stall_cnt_o
);
  localparam logic [32:0] RAM_LIMIT = 33'(RAM_BYTES);

  rd_owner_e   state_q, state_d;
  logic        dmni_sel, cpu_sel, active, oor, rd_issue, rd_oor_q;
  logic [3:0]  sel_we;
  logic [31:0] sel_addr, sel_data, rd_data, cpu_data_q;

  always_comb begin
    dmni_sel = bus.dmni_en_i;
    cpu_sel  = !bus.dmni_en_i && bus.cpu_req_i;
    active   = dmni_sel || cpu_sel;
    sel_we   = 4'h0;
    sel_addr = 32'h0;
    sel_data = 32'h0;
    if (dmni_sel) begin
      sel_we   = bus.dmni_we_i;
      sel_addr = bus.dmni_addr_i;
      sel_data = bus.dmni_data_i;
    end else if (cpu_sel) begin
      sel_we   = bus.cpu_we_i;
      sel_addr = bus.cpu_addr_i;
      sel_data = bus.cpu_data_i;
    end
    oor      = active && ({1'b0, sel_addr} >= RAM_LIMIT);
    rd_issue = active && (sel_we == 4'h0);

    bus.cpu_gnt_o  = cpu_sel;
    bus.ram_en_o   = active && !oor && rst_ni;
    bus.ram_we_o   = oor ? 4'h0 : sel_we;
    bus.ram_addr_o = sel_addr;
    bus.ram_data_o = sel_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d          = IDLE;
    bus.cpu_rvalid_o = (state_q == RD_CPU);
    if (rd_issue)
      state_d = dmni_sel ? RD_DMNI : RD_CPU;
  end

  // An out-of-range read never reached the RAM, so its data slot is forced to zero.
  assign rd_data         = rd_oor_q ? 32'h0 : bus.ram_data_i;
  assign bus.dmni_data_o = rd_data;
  assign bus.cpu_data_o  = bus.cpu_rvalid_o ? rd_data : cpu_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_oor_q   <= 1'b0;
      cpu_data_q <= 32'h0;
      oor_err_o  <= 1'b0;
    end else begin
      rd_oor_q <= rd_issue && oor;
      if (bus.cpu_rvalid_o)
        cpu_data_q <= rd_data;
      if (oor)
        oor_err_o <= 1'b1;
      else if (oor_clr_i)
        oor_err_o <= 1'b0;
    end
  end

  StallMonitor #(.STALL_LIMIT(STALL_LIMIT)) u_stall (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (bus.cpu_req_i),
    .gnt    (cpu_sel),
    .starve (starve_o),
    .total  (stall_cnt_o)
  );
endmodule

// File: tb/tb_dmni_mem_arbiter.sv
// Scenario bench for dmni_mem_arbiter with a behavioural RAM and a CPU read-data scoreboard.
module tb_dmni_mem_arbiter;
  localparam int RAM_BYTES   = 1024;
  localparam int STALL_LIMIT = 4;
  localparam logic [31:0] RAM_TOP = 32'(RAM_BYTES);

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        oor_clr_i;
  logic        starve_o, oor_err_o;
  logic [31:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ram_mem [256];
  logic [31:0] shadow  [256];

  dmni_mem_arbiter_if bus();

  dmni_mem_arbiter #(.RAM_BYTES(RAM_BYTES), .STALL_LIMIT(STALL_LIMIT)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .oor_clr_i   (oor_clr_i),
    .starve_o    (starve_o),
    .oor_err_o   (oor_err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous single-port RAM, read-first, one cycle latency.
  logic [31:0] ram_w;
  always @(posedge clk_i) begin
    if (bus.ram_en_o) begin
      ram_w = ram_mem[bus.ram_addr_o[9:2]];
      for (int b = 0; b < 4; b++)
        if (bus.ram_we_o[b]) ram_w[8*b +: 8] = bus.ram_data_o[8*b +: 8];
      ram_mem[bus.ram_addr_o[9:2]] <= ram_w;
      bus.ram_data_i <= ram_mem[bus.ram_addr_o[9:2]];
    end
  end

  // Scoreboard: expectations come from requester inputs and the shadow memory.
  logic        sb_dsel, sb_csel;
  logic [3:0]  sb_we;
  logic [31:0] sb_a, sb_d, sb_w, sb_exp;
  always @(negedge clk_i) begin
    if (bus.cpu_rvalid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_rvalid: got rvalid with data %h, required no rvalid", bus.cpu_data_o);
      end else begin
        sb_exp = exp_q.pop_front();
        if (bus.cpu_data_o !== sb_exp) begin
          errors++;
          $display("FAIL sb_cpu_data: got %h, required %h", bus.cpu_data_o, sb_exp);
        end
      end
    end
    if (rst_ni) begin
      sb_dsel = bus.dmni_en_i;
      sb_csel = !bus.dmni_en_i && bus.cpu_req_i;
      sb_we = sb_dsel ? bus.dmni_we_i : bus.cpu_we_i;
      sb_a  = sb_dsel ? bus.dmni_addr_i : bus.cpu_addr_i;
      sb_d  = sb_dsel ? bus.dmni_data_i : bus.cpu_data_i;
      if (sb_csel && sb_we == 4'h0)
        exp_q.push_back((sb_a >= RAM_TOP) ? 32'h0 : shadow[sb_a[9:2]]);
      if ((sb_dsel || sb_csel) && sb_a < RAM_TOP) begin
        sb_w = shadow[sb_a[9:2]];
        for (int b = 0; b < 4; b++)
          if (sb_we[b]) sb_w[8*b +: 8] = sb_d[8*b +: 8];
        shadow[sb_a[9:2]] = sb_w;
      end
    end
  end

  task automatic tick(); @(posedge clk_i); #1; endtask
  task automatic mid();  @(negedge clk_i);     endtask

  task automatic idle_inputs();
    bus.dmni_en_i = 0; bus.dmni_we_i = 0; bus.dmni_addr_i = 0; bus.dmni_data_i = 0;
    bus.cpu_req_i = 0; bus.cpu_we_i = 0;  bus.cpu_addr_i = 0;  bus.cpu_data_i = 0;
    oor_clr_i = 0;
  endtask

  task automatic do_reset();
    tick(); rst_ni = 0; idle_inputs();
    tick(); tick(); exp_q.delete(); rst_ni = 1;
  endtask

  task automatic dmni_write(input logic [31:0] a, input logic [31:0] d);
    tick(); bus.dmni_en_i = 1; bus.dmni_we_i = 4'hF; bus.dmni_addr_i = a; bus.dmni_data_i = d;
    mid();
    tick(); idle_inputs();
  endtask

  task automatic cpu_read_in(input logic [31:0] a);
    bus.cpu_req_i = 1; bus.cpu_we_i = 4'h0; bus.cpu_addr_i = a;
  endtask

  task automatic test_reset();
    bus.dmni_en_i = 1; bus.dmni_addr_i = 32'h44;
    mid();
    checks++; if (bus.cpu_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b required 0", bus.cpu_rvalid_o); end
    checks++; if (bus.cpu_data_o !== 32'h0) begin errors++; $display("FAIL rst_cpu_data: got %h required 0", bus.cpu_data_o); end
    checks++; if (starve_o !== 1'b0) begin errors++; $display("FAIL rst_starve: got %b required 0", starve_o); end
    checks++; if (oor_err_o !== 1'b0) begin errors++; $display("FAIL rst_oor: got %b required 0", oor_err_o); end
    checks++; if (stall_cnt_o !== 32'h0) begin errors++; $display("FAIL rst_stall_cnt: got %h required 0", stall_cnt_o); end
    checks++; if (bus.ram_en_o !== 1'b0) begin errors++; $display("FAIL rst_ram_en_gated: got %b required 0", bus.ram_en_o); end
    checks++; if (bus.ram_addr_o !== 32'h44) begin errors++; $display("FAIL rst_ram_addr: got %h required 00000044", bus.ram_addr_o); end
    tick(); idle_inputs(); rst_ni = 1;
  endtask

  task automatic test_cpu_read();
    dmni_write(32'h10, 32'hCAFEBABE);
    dmni_write(32'h80, 32'h0BADF00D);
    tick(); cpu_read_in(32'h10); mid();
    checks++; if (bus.cpu_gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b required 1", bus.cpu_gnt_o); end
    checks++; if (bus.ram_en_o !== 1'b1) begin errors++; $display("FAIL rd_ram_en: got %b required 1", bus.ram_en_o); end
    checks++; if (bus.ram_addr_o !== 32'h10) begin errors++; $display("FAIL rd_ram_addr: got %h required 00000010", bus.ram_addr_o); end
    tick(); idle_inputs(); mid();
    checks++; if (bus.cpu_rvalid_o !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b required 1", bus.cpu_rvalid_o); end
    checks++; if (bus.cpu_data_o !== 32'hCAFEBABE) begin errors++; $display("FAIL rd_data: got %h required cafebabe", bus.cpu_data_o); end
    tick(); bus.dmni_en_i = 1; bus.dmni_addr_i = 32'h80; mid();
    tick(); idle_inputs(); mid();
    checks++; if (bus.dmni_data_o !== 32'h0BADF00D) begin errors++; $display("FAIL rd_dmni_data: got %h required 0badf00d", bus.dmni_data_o); end
    tick(); mid();
    tick(); mid();
    checks++; if (bus.cpu_data_o !== 32'hCAFEBABE) begin errors++; $display("FAIL rd_hold: got %h required cafebabe", bus.cpu_data_o); end
    checks++; if (bus.cpu_rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_rvalid_once: got %b required 0", bus.cpu_rvalid_o); end
  endtask

  task automatic test_priority();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(); bus.dmni_en_i = 1; bus.dmni_addr_i = 32'h80; cpu_read_in(32'h10); mid();
      checks++; if (bus.cpu_gnt_o !== 1'b0) begin errors++; $display("FAIL prio_gnt_low[%0d]: got %b required 0", i, bus.cpu_gnt_o); end
      checks++; if (stall_cnt_o !== 32'(i)) begin errors++; $display("FAIL prio_stall_cnt[%0d]: got %0d required %0d", i, stall_cnt_o, i); end
    end
    tick(); bus.dmni_en_i = 0; mid();
    checks++; if (bus.cpu_gnt_o !== 1'b1) begin errors++; $display("FAIL prio_gnt_c10: got %b required 1", bus.cpu_gnt_o); end
    checks++; if (stall_cnt_o !== 32'd10) begin errors++; $display("FAIL prio_stall_c10: got %0d required 10", stall_cnt_o); end
    tick(); idle_inputs(); mid();
    checks++; if (stall_cnt_o !== 32'd10) begin errors++; $display("FAIL prio_stall_after_gnt: got %0d required 10", stall_cnt_o); end
  endtask

  task automatic test_starve();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(); bus.dmni_en_i = 1; bus.dmni_addr_i = 32'h80; cpu_read_in(32'h10); mid();
      checks++; if (starve_o !== (i >= STALL_LIMIT)) begin errors++; $display("FAIL starve_c%0d: got %b required %b", i, starve_o, i >= STALL_LIMIT); end
    end
    tick(); bus.dmni_en_i = 0; mid();
    checks++; if (starve_o !== 1'b1) begin errors++; $display("FAIL starve_at_gnt: got %b required 1", starve_o); end
    tick(); idle_inputs(); mid();
    checks++; if (starve_o !== 1'b0) begin errors++; $display("FAIL starve_after_gnt: got %b required 0", starve_o); end
    for (int i = 0; i < 5; i++) begin
      tick(); bus.dmni_en_i = 1; bus.dmni_addr_i = 32'h80; cpu_read_in(32'h10); mid();
    end
    tick(); bus.cpu_req_i = 0; mid();
    checks++; if (starve_o !== 1'b1) begin errors++; $display("FAIL starve_withdraw_c0: got %b required 1", starve_o); end
    tick(); mid();
    checks++; if (starve_o !== 1'b0) begin errors++; $display("FAIL starve_withdraw_c1: got %b required 0", starve_o); end
    tick(); idle_inputs();
  endtask

  task automatic test_oor();
    dmni_write(32'h0, 32'h5A5A5A5A);
    tick(); bus.cpu_req_i = 1; bus.cpu_we_i = 4'hF; bus.cpu_addr_i = RAM_TOP; bus.cpu_data_i = 32'hFFFFFFFF; mid();
    checks++; if (bus.cpu_gnt_o !== 1'b1) begin errors++; $display("FAIL oor_gnt: got %b required 1", bus.cpu_gnt_o); end
    checks++; if (bus.ram_en_o !== 1'b0) begin errors++; $display("FAIL oor_ram_en: got %b required 0", bus.ram_en_o); end
    checks++; if (bus.ram_we_o !== 4'h0) begin errors++; $display("FAIL oor_ram_we: got %h required 0", bus.ram_we_o); end
    tick(); idle_inputs(); mid();
    checks++; if (oor_err_o !== 1'b1) begin errors++; $display("FAIL oor_flag_set: got %b required 1", oor_err_o); end
    tick(); oor_clr_i = 1; mid();
    tick(); oor_clr_i = 0; mid();
    checks++; if (oor_err_o !== 1'b0) begin errors++; $display("FAIL oor_flag_clr: got %b required 0", oor_err_o); end
    tick(); bus.dmni_en_i = 1; bus.dmni_addr_i = RAM_TOP + 32'd8; oor_clr_i = 1; mid();
    checks++; if (bus.ram_en_o !== 1'b0) begin errors++; $display("FAIL oor_dmni_ram_en: got %b required 0", bus.ram_en_o); end
    tick(); idle_inputs(); mid();
    checks++; if (oor_err_o !== 1'b1) begin errors++; $display("FAIL oor_err_beats_clr: got %b required 1", oor_err_o); end
    checks++; if (bus.dmni_data_o !== 32'h0) begin errors++; $display("FAIL oor_dmni_rdata: got %h required 0", bus.dmni_data_o); end
    tick(); cpu_read_in(RAM_TOP + 32'd4); mid();
    tick(); idle_inputs(); mid();
    checks++; if (bus.cpu_rvalid_o !== 1'b1 || bus.cpu_data_o !== 32'h0) begin errors++; $display("FAIL oor_cpu_rdata: got rvalid=%b data=%h required rvalid=1 data=0", bus.cpu_rvalid_o, bus.cpu_data_o); end
    tick(); cpu_read_in(32'h0); mid();
    tick(); idle_inputs(); mid();
    checks++; if (bus.cpu_data_o !== 32'h5A5A5A5A) begin errors++; $display("FAIL oor_no_alias_write: got %h required 5a5a5a5a", bus.cpu_data_o); end
    tick(); oor_clr_i = 1; mid();
    tick(); idle_inputs();
  endtask

  task automatic test_back_to_back();
    dmni_write(32'h40, 32'h11112222);
    dmni_write(32'h44, 32'h33334444);
    tick(); bus.dmni_en_i = 1; bus.dmni_addr_i = 32'h40; mid();
    tick(); bus.dmni_en_i = 0; bus.dmni_addr_i = 0; cpu_read_in(32'h44); mid();
    checks++; if (bus.dmni_data_o !== 32'h11112222) begin errors++; $display("FAIL b2b_dmni_data: got %h required 11112222", bus.dmni_data_o); end
    checks++; if (bus.cpu_rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_no_rvalid_n1: got %b required 0", bus.cpu_rvalid_o); end
    checks++; if (bus.cpu_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt: got %b required 1", bus.cpu_gnt_o); end
    tick(); idle_inputs(); mid();
    checks++; if (bus.cpu_rvalid_o !== 1'b1) begin errors++; $display("FAIL b2b_rvalid_n2: got %b required 1", bus.cpu_rvalid_o); end
    checks++; if (bus.cpu_data_o !== 32'h33334444) begin errors++; $display("FAIL b2b_cpu_data: got %h required 33334444", bus.cpu_data_o); end
  endtask

  task automatic test_reset_inflight();
    tick(); bus.dmni_en_i = 1; bus.dmni_we_i = 4'hF; bus.dmni_addr_i = RAM_TOP; cpu_read_in(32'h44); mid();
    tick(); bus.dmni_en_i = 0; bus.dmni_we_i = 0; bus.dmni_addr_i = 0; mid();
    checks++; if (bus.cpu_gnt_o !== 1'b1) begin errors++; $display("FAIL rstf_gnt: got %b required 1", bus.cpu_gnt_o); end
    tick(); idle_inputs(); rst_ni = 0; exp_q.delete(); mid();
    checks++; if (bus.cpu_rvalid_o !== 1'b0) begin errors++; $display("FAIL rstf_rvalid: got %b required 0", bus.cpu_rvalid_o); end
    checks++; if (bus.cpu_data_o !== 32'h0) begin errors++; $display("FAIL rstf_cpu_data: got %h required 0", bus.cpu_data_o); end
    checks++; if (oor_err_o !== 1'b0) begin errors++; $display("FAIL rstf_oor: got %b required 0", oor_err_o); end
    checks++; if (starve_o !== 1'b0) begin errors++; $display("FAIL rstf_starve: got %b required 0", starve_o); end
    checks++; if (stall_cnt_o !== 32'h0) begin errors++; $display("FAIL rstf_stall_cnt: got %0d required 0", stall_cnt_o); end
    tick(); rst_ni = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      checks++; if (bus.cpu_rvalid_o !== 1'b0) begin errors++; $display("FAIL rstf_post_rvalid[%0d]: got %b required 0", i, bus.cpu_rvalid_o); end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_priority();
    test_starve();
    test_oor();
    test_back_to_back();
    test_reset_inflight();
    mid();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending reads required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
